arm_sequencer: RTL

//   Sequences the servo/magnet arm for the rover's top-level controller. Arbitrates pick and drop

---
 rtl/arm_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/arm_sequencer.sv
// rtl/arm_sequencer.sv - pick/drop arbiter and servo command sequencer for the rover arm
// Optional move watchdog and FAULT state enabled by defining ARM_TIMEOUT_EN.
module arm_sequencer #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 400_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pick_req,
  input  logic       drop_req,
  input  logic       move_flag,
  input  logic       fault_clr,
  output logic [1:0] servo_flag,
  output logic       pick_ack,
  output logic       drop_ack,
  output logic       busy,
  output logic       active_op,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
`ifdef ARM_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;

  state_t     state, state_n;
  logic [1:0] servo_n;
  logic       pick_ack_n, drop_ack_n, busy_n, op_n;
  logic       last_grant, last_n;
  logic       grant;
  logic [7:0] gap_cnt, gap_n;
  logic       move_flag_d;
  logic       move_rise;

  assign move_rise = move_flag & ~move_flag_d;

`ifdef ARM_TIMEOUT_EN
  logic [31:0] tmo_cnt, tmo_n;
  logic        fault_q, fault_n;
  assign fault = fault_q;
`else
  logic unused_cfg;
  assign unused_cfg = fault_clr ^ (TIMEOUT_CYCLES == 0);
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      servo_flag  <= 2'b00;
      pick_ack    <= 1'b0;
      drop_ack    <= 1'b0;
      busy        <= 1'b0;
      active_op   <= 1'b0;
      last_grant  <= 1'b0;
      gap_cnt     <= 8'd0;
      move_flag_d <= 1'b0;
`ifdef ARM_TIMEOUT_EN
      tmo_cnt     <= 32'd0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      servo_flag  <= servo_n;
      pick_ack    <= pick_ack_n;
      drop_ack    <= drop_ack_n;
      busy        <= busy_n;
      active_op   <= op_n;
      last_grant  <= last_n;
      gap_cnt     <= gap_n;
      move_flag_d <= move_flag;
`ifdef ARM_TIMEOUT_EN
      tmo_cnt     <= tmo_n;
      fault_q     <= fault_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    servo_n    = servo_flag;
    pick_ack_n = 1'b0;
    drop_ack_n = 1'b0;
    busy_n     = busy;
    op_n       = active_op;
    last_n     = last_grant;
    gap_n      = gap_cnt;
    grant      = 1'b0;
`ifdef ARM_TIMEOUT_EN
    tmo_n      = tmo_cnt;
    fault_n    = fault_q;
`endif
    case (state)
      S_IDLE: begin
        if (pick_req | drop_req) begin
          // On a tie the requester not served last time wins
          grant   = (pick_req & drop_req) ? ~last_grant : pick_req;
          op_n    = grant;
          servo_n = {1'b0, grant};
          last_n  = grant;
          busy_n  = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        servo_n = {1'b1, active_op};
`ifdef ARM_TIMEOUT_EN
        tmo_n   = 32'd0;
`endif
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (move_rise) begin
          servo_n    = 2'b00;
          pick_ack_n = active_op;
          drop_ack_n = ~active_op;
          gap_n      = 8'd0;
          state_n    = S_GAP;
        end
`ifdef ARM_TIMEOUT_EN
        else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          servo_n = 2'b00;
          fault_n = 1'b1;
          state_n = S_FAULT;
        end else begin
          tmo_n = tmo_cnt + 32'd1;
        end
`endif
      end
      S_GAP: begin
        if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          gap_n = gap_cnt + 8'd1;
        end
      end
`ifdef ARM_TIMEOUT_EN
      S_FAULT: begin
        servo_n = 2'b00;
        if (fault_clr) begin
          fault_n = 1'b0;
          gap_n   = 8'd0;
          state_n = S_GAP;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

endmodule
